nv_nvdla_cdma_wt_rsp_demux: RTL and testbench
=============================================

# nv_nvdla_cdma_wt_rsp_demux

Return-path companion to the CDMA weight strict-priority arbiter. It records the source (requester 0 or 1) and beat count of every arbitrated weight read request accepted by the DMA read port. It steers the in-order DMA read response beats back to the requester that issued each request. It also drives the arbiter's grant-blocking input whenever its tag store is full.

## Interface
- DEPTH, 8, tag FIFO entries (max outstanding requests; power of 2)
- RSP_W, 514, response payload width (512 data + 2 mask)
- SIZE_W, 4, request size field width (beats minus 1)
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; one clock, asynchronous assert, active-low
- req_accept  in  1  arbitrated request accepted downstream this cycle (valid & ready)
- req_src  in  1  source of accepted request: 0 = gnt0, 1 = gnt1
- req_size  in  SIZE_W  beats minus 1 of accepted request
- arb_busy  out  1  tag FIFO full; wired to arbiter gnt_busy
- dma_rd_rsp_valid  in  1  response beat valid
- dma_rd_rsp_ready  out  1  response beat accepted
- dma_rd_rsp_pd  in  RSP_W  response beat payload
- rsp0_valid / rsp1_valid  out  1  beat for requester 0 / 1
- rsp0_ready / rsp1_ready  in  1  requester backpressure
- rsp0_pd / rsp1_pd  out  RSP_W  payload copy
- rsp0_last / rsp1_last  out  1  last beat of the current request
- outs0_cnt / outs1_cnt  out  $clog2(DEPTH)+1  outstanding requests per source
- idle  out  1  no outstanding requests
- err_ovf  out  1  sticky: req_accept seen while arb_busy

## Operation
- Tag = {src, size}. req_accept pushes the tag and increments outs<src>_cnt.
- Head tag selects the route. rspN_valid = dma_rd_rsp_valid & tag_nonempty & (head.src==N). Other rsp valid = 0.
- dma_rd_rsp_ready = tag_nonempty & ready of the selected requester.
- Both rspN_pd carry dma_rd_rsp_pd unconditionally.
- Beat counter beat_cnt (SIZE_W) counts accepted beats of the head request. rspN_last = (beat_cnt == head.size).
- On an accepted last beat: pop the tag, clear beat_cnt, decrement outs<head.src>_cnt. Otherwise beat_cnt++.
- Response with empty tag FIFO: ready = 0, beat stalls. This is a protocol violation, not dropped.
- Push and pop in the same cycle: both occur, FIFO count unchanged, per-source counters adjust independently (same source: net 0).
- arb_busy = (fifo_count == DEPTH). Push while full is dropped and sets err_ovf; err_ovf clears only on reset.
- idle = (fifo_count == 0).

## Timing
- Reset values: fifo empty, beat_cnt 0, outs0_cnt 0, outs1_cnt 0, err_ovf 0, arb_busy 0, idle 1, dma_rd_rsp_ready 0, rsp0_valid 0, rsp1_valid 0.
- Response routing is combinational, zero latency. rspN_ready to dma_rd_rsp_ready is a combinational path.
- A pushed tag is usable for routing from the next cycle. A response in the same cycle as the first push to an empty FIFO stalls one cycle.
- arb_busy derives from registered count only. There is no combinational path from req_accept.
- Reset mid-burst discards all tags and partial counts immediately, asynchronously.

## Structure
- Shared package holds the tag struct {src 1b, size SIZE_W}, RSP_W, SIZE_W and DEPTH defaults.
- Sub-module nv_nvdla_cdma_wt_tag_fifo: flop-based DEPTH-entry FIFO with push, pop, head, count and full outputs.
- Top holds the beat counter, outstanding counters, routing and the error flag.

## Test plan
- Push {src0,size 3}, then stream 4 beats with rsp0_ready=1 -> rsp0_valid 4 cycles, rsp0_last on beat 4 only, outs0_cnt 1→0, idle=1.
- Push src1 size0, src0 size1, src1 size2 -> beats route 1 | 0,0 | 1,1,1 in order, correct last on each; rsp1 never sees src0 beats.
- Hold rsp1_ready=0 for 5 cycles mid-burst -> dma_rd_rsp_ready=0, beat_cnt frozen, then resumes with no loss or duplication.
- Push 8 tags -> arb_busy=1. Push a 9th -> err_ovf=1, count stays 8. Pop a last beat -> arb_busy=0 next cycle.
- Simultaneous push (src0) and last-beat pop (src0) at count 3 -> count 3, outs0_cnt unchanged.
- Assert nvdla_core_rstn low mid-burst (beat 2 of 4) -> all outputs at reset values. A response after reset stalls until a new push.

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_rsp_demux_pkg.sv
// Shared types and default sizes for the CDMA weight response demux.
package nv_nvdla_cdma_wt_rsp_demux_pkg;

  localparam int unsigned WT_DEPTH  = 8;
  localparam int unsigned WT_RSP_W  = 514;
  localparam int unsigned WT_SIZE_W = 4;

  // Per-request routing tag: issuing requester and beats minus 1.
  typedef struct packed {
    logic                 src;
    logic [WT_SIZE_W-1:0] size;
  } wt_tag_t;

endpackage

// File: rtl/nv_nvdla_cdma_wt_tag_fifo.sv
// Flop-based tag FIFO holding the route of every outstanding weight read.
module nv_nvdla_cdma_wt_tag_fifo
  import nv_nvdla_cdma_wt_rsp_demux_pkg::*;
#(
  parameter int unsigned DEPTH = WT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wt_tag_t                push_tag,
  input  logic                   pop,
  output wt_tag_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wt_tag_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push   = push & ~full;
  assign do_pop    = pop & (count != '0);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/nv_nvdla_cdma_wt_rsp_demux.sv
// Steers in-order DMA weight read response beats back to the requester that
// issued each request, and blocks the arbiter while the tag store is full.
module nv_nvdla_cdma_wt_rsp_demux
  import nv_nvdla_cdma_wt_rsp_demux_pkg::*;
#(
  parameter int unsigned DEPTH = WT_DEPTH,
  parameter int unsigned RSP_W = WT_RSP_W
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   req_accept,
  input  logic                   req_src,
  input  logic [WT_SIZE_W-1:0]   req_size,
  output logic                   arb_busy,
  input  logic                   dma_rd_rsp_valid,
  output logic                   dma_rd_rsp_ready,
  input  logic [RSP_W-1:0]       dma_rd_rsp_pd,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [RSP_W-1:0]       rsp0_pd,
  output logic                   rsp0_last,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [RSP_W-1:0]       rsp1_pd,
  output logic                   rsp1_last,
  output logic [$clog2(DEPTH):0] outs0_cnt,
  output logic [$clog2(DEPTH):0] outs1_cnt,
  output logic                   idle,
  output logic                   err_ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wt_tag_t              push_tag;
  wt_tag_t              head;
  logic [CW-1:0]        tag_count;
  logic                 tag_full;
  logic                 tag_nonempty;
  logic                 push;
  logic                 pop;
  logic                 sel_ready;
  logic                 beat_acc;
  logic                 last_c;
  logic [WT_SIZE_W-1:0] beat_cnt;

  assign push_tag.src  = req_src;
  assign push_tag.size = req_size;
  assign push          = req_accept & ~tag_full;

  nv_nvdla_cdma_wt_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .count    (tag_count),
    .full     (tag_full)
  );

  // Routing is combinational off the head tag; an empty store stalls the DMA.
  assign tag_nonempty     = (tag_count != '0);
  assign sel_ready        = head.src ? rsp1_ready : rsp0_ready;
  assign dma_rd_rsp_ready = tag_nonempty & sel_ready;
  assign rsp0_valid       = dma_rd_rsp_valid & tag_nonempty & ~head.src;
  assign rsp1_valid       = dma_rd_rsp_valid & tag_nonempty & head.src;
  assign rsp0_pd          = dma_rd_rsp_pd;
  assign rsp1_pd          = dma_rd_rsp_pd;

  assign last_c    = (beat_cnt == head.size);
  assign rsp0_last = last_c;
  assign rsp1_last = last_c;
  assign beat_acc  = dma_rd_rsp_valid & dma_rd_rsp_ready;
  assign pop       = beat_acc & last_c;

  assign arb_busy = tag_full;
  assign idle     = ~tag_nonempty;

  // Beat position within the head request, per-source outstanding counts
  // and the sticky overflow flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt  <= '0;
      outs0_cnt <= '0;
      outs1_cnt <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (pop) begin
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + WT_SIZE_W'(1);
      end
      outs0_cnt <= outs0_cnt + CW'(push & ~req_src) - CW'(pop & ~head.src);
      outs1_cnt <= outs1_cnt + CW'(push & req_src) - CW'(pop & head.src);
      err_ovf   <= err_ovf | (req_accept & tag_full);
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_rsp_demux.sv
// Bench for the weight response demux: directed scenarios plus a random run
// against a queue-based model of outstanding requests.
`timescale 1ns/1ps
module tb_nv_nvdla_cdma_wt_rsp_demux;

  localparam int unsigned RSP_W  = 514;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CW     = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_accept;
  logic              req_src;
  logic [SIZE_W-1:0] req_size;
  logic              arb_busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RSP_W-1:0]  rsp_pd;
  logic              rsp0_valid, rsp0_ready, rsp0_last;
  logic              rsp1_valid, rsp1_ready, rsp1_last;
  logic [RSP_W-1:0]  rsp0_pd, rsp1_pd;
  logic [CW-1:0]     outs0_cnt, outs1_cnt;
  logic              idle, err_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_cdma_wt_rsp_demux dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .req_accept       (req_accept),
    .req_src          (req_src),
    .req_size         (req_size),
    .arb_busy         (arb_busy),
    .dma_rd_rsp_valid (rsp_valid),
    .dma_rd_rsp_ready (rsp_ready),
    .dma_rd_rsp_pd    (rsp_pd),
    .rsp0_valid       (rsp0_valid),
    .rsp0_ready       (rsp0_ready),
    .rsp0_pd          (rsp0_pd),
    .rsp0_last        (rsp0_last),
    .rsp1_valid       (rsp1_valid),
    .rsp1_ready       (rsp1_ready),
    .rsp1_pd          (rsp1_pd),
    .rsp1_last        (rsp1_last),
    .outs0_cnt        (outs0_cnt),
    .outs1_cnt        (outs1_cnt),
    .idle             (idle),
    .err_ovf          (err_ovf)
  );

  // Reference: list of outstanding requests in issue order and beats already
  // delivered for the oldest one.
  typedef struct { bit src; int size; } mtag_t;
  mtag_t mq[$];
  int    mbeat = 0;
  bit    merr  = 1'b0;

  function automatic int m_outs(input bit s);
    int n = 0;
    foreach (mq[i]) if (mq[i].src == s) n++;
    return n;
  endfunction

  function automatic bit m_valid(input bit s);
    return rsp_valid && mq.size() > 0 && mq[0].src == s;
  endfunction

  function automatic bit m_ready();
    if (mq.size() == 0) return 1'b0;
    return mq[0].src ? rsp1_ready : rsp0_ready;
  endfunction

  function automatic bit m_last();
    return mq.size() > 0 && mbeat == mq[0].size;
  endfunction

  task automatic m_clear();
    mq.delete();
    mbeat = 0;
    merr  = 1'b0;
  endtask

  task automatic drive(input bit acc, input bit src, input int size,
                       input bit rv, input bit r0, input bit r1);
    logic [543:0] w;
    for (int k = 0; k < 17; k++) w[k*32 +: 32] = $urandom;
    req_accept = acc;
    req_src    = src;
    req_size   = SIZE_W'(size);
    rsp_valid  = rv;
    rsp0_ready = r0;
    rsp1_ready = r1;
    rsp_pd     = w[RSP_W-1:0];
    #1;
  endtask

  // Advance one clock and apply this cycle's request/beat to the model.
  task automatic tick();
    int old_n;
    bit acc;
    bit last;
    @(posedge clk);
    old_n = mq.size();
    acc   = 1'b0;
    last  = 1'b0;
    if (old_n > 0) begin
      acc  = rsp_valid && (mq[0].src ? rsp1_ready : rsp0_ready);
      last = (mbeat == mq[0].size);
    end
    if (acc) begin
      if (last) begin
        mq.delete(0);
        mbeat = 0;
      end else begin
        mbeat++;
      end
    end
    if (req_accept) begin
      if (old_n == DEPTH) merr = 1'b1;
      else mq.push_back('{src: req_src, size: int'(req_size)});
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (mq.size() > 0 && n < 100) begin
      drive(0, 0, 0, 1, 1, 1);
      tick();
      n++;
    end
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (idle !== 1'b1 || mq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: idle=%b model_left=%0d, want idle=1 left=0", tag, idle, mq.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_clear();
    drive(0, 0, 0, 1, 1, 1);
    checks++;
    if ({rsp_ready, rsp0_valid, rsp1_valid, arb_busy, idle, err_ovf} !== 6'b000010 ||
        outs0_cnt !== '0 || outs1_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b v0=%b v1=%b busy=%b idle=%b err=%b o0=%0d o1=%0d, want 0 0 0 0 1 0 0 0",
               rsp_ready, rsp0_valid, rsp1_valid, arb_busy, idle, err_ovf, outs0_cnt, outs1_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_burst();
    drive(1, 0, 3, 0, 1, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_last !== (i == 3) || rsp_ready !== 1'b1) begin
        errors++;
        $display("FAIL single_beat%0d: v0=%b v1=%b last=%b rdy=%b, want 1 0 %b 1",
                 i, rsp0_valid, rsp1_valid, rsp0_last, rsp_ready, i == 3);
      end
      checks++;
      if (outs0_cnt !== CW'(1) || rsp0_pd !== rsp_pd || rsp1_pd !== rsp_pd) begin
        errors++;
        $display("FAIL single_cnt_pd%0d: outs0=%0d pd_match0=%b pd_match1=%b, want 1 1 1",
                 i, outs0_cnt, rsp0_pd === rsp_pd, rsp1_pd === rsp_pd);
      end
      tick();
    end
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (idle !== 1'b1 || outs0_cnt !== '0) begin
      errors++;
      $display("FAIL single_done: idle=%b outs0=%0d, want 1 0", idle, outs0_cnt);
    end
  endtask

  task automatic test_mixed_route();
    bit s_seq[6] = '{1, 0, 0, 1, 1, 1};
    bit l_seq[6] = '{1, 0, 1, 0, 0, 1};
    drive(1, 1, 0, 0, 1, 1); tick();
    drive(1, 0, 1, 0, 1, 1); tick();
    drive(1, 1, 2, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (outs0_cnt !== CW'(1) || outs1_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL mixed_outs: outs0=%0d outs1=%0d, want 1 2", outs0_cnt, outs1_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 1, 1);
      checks++;
      if (rsp0_valid !== !s_seq[i] || rsp1_valid !== s_seq[i] ||
          (s_seq[i] ? rsp1_last : rsp0_last) !== l_seq[i]) begin
        errors++;
        $display("FAIL mixed_beat%0d: v0=%b v1=%b last0=%b last1=%b, want v0=%b v1=%b last=%b",
                 i, rsp0_valid, rsp1_valid, rsp0_last, rsp1_last, !s_seq[i], s_seq[i], l_seq[i]);
      end
      tick();
    end
    drain("mixed");
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    drive(1, 1, 4, 0, 1, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      bit r1 = !(i >= 2 && i < 7);
      drive(0, 0, 0, 1, 1, r1);
      checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_ready !== r1 || rsp1_last !== m_last()) begin
        errors++;
        $display("FAIL bp_cycle%0d: v1=%b v0=%b rdy=%b last=%b, want 1 0 %b %b",
                 i, rsp1_valid, rsp0_valid, rsp_ready, rsp1_last, r1, m_last());
      end
      if (r1) accepted++;
      tick();
    end
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (accepted != 5 || idle !== 1'b1 || outs1_cnt !== '0) begin
      errors++;
      $display("FAIL bp_done: accepted=%0d idle=%b outs1=%0d, want 5 1 0", accepted, idle, outs1_cnt);
    end
  endtask

  task automatic test_push_pop_same();
    drive(1, 0, 0, 0, 1, 1); tick();
    drive(1, 1, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 0, 1, 1); tick();
    drive(1, 0, 1, 1, 1, 1);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_last !== 1'b1 || outs0_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL pp_before: v0=%b last=%b outs0=%0d, want 1 1 2", rsp0_valid, rsp0_last, outs0_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (outs0_cnt !== CW'(2) || outs1_cnt !== CW'(1) || idle !== 1'b0 || mq.size() != 3) begin
      errors++;
      $display("FAIL pp_after: outs0=%0d outs1=%0d idle=%b, want 2 1 0", outs0_cnt, outs1_cnt, idle);
    end
    drain("pp");
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 0, 0, 1, 1);
      tick();
    end
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (arb_busy !== 1'b1 || err_ovf !== 1'b0 ||
        outs0_cnt !== CW'(m_outs(0)) || outs1_cnt !== CW'(m_outs(1))) begin
      errors++;
      $display("FAIL full_busy: busy=%b err=%b outs0=%0d outs1=%0d, want 1 0 %0d %0d",
               arb_busy, err_ovf, outs0_cnt, outs1_cnt, m_outs(0), m_outs(1));
    end
    drive(1, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (err_ovf !== 1'b1 || arb_busy !== 1'b1 || mq.size() != 8 ||
        outs0_cnt !== CW'(m_outs(0)) || outs1_cnt !== CW'(m_outs(1))) begin
      errors++;
      $display("FAIL overflow: err=%b busy=%b outs0=%0d outs1=%0d, want 1 1 %0d %0d",
               err_ovf, arb_busy, outs0_cnt, outs1_cnt, m_outs(0), m_outs(1));
    end
    drive(0, 0, 0, 1, 1, 1);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++;
    if (arb_busy !== 1'b0 || err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL unfull: busy=%b err=%b, want 0 1", arb_busy, err_ovf);
    end
    drain("full");
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 0, 3, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 1, 1, 1);
    #2;
    rstn = 1'b0;
    #1;
    m_clear();
    checks++;
    if ({rsp_ready, rsp0_valid, rsp1_valid, arb_busy, idle, err_ovf} !== 6'b000010 ||
        outs0_cnt !== '0 || outs1_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b v0=%b v1=%b busy=%b idle=%b err=%b o0=%0d o1=%0d, want 0 0 0 0 1 0 0 0",
               rsp_ready, rsp0_valid, rsp1_valid, arb_busy, idle, err_ovf, outs0_cnt, outs1_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 1);
      checks++;
      if (rsp_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stall%0d: rdy=%b v0=%b v1=%b, want 0 0 0", i, rsp_ready, rsp0_valid, rsp1_valid);
      end
      tick();
    end
    drive(1, 0, 1, 1, 1, 1);
    checks++;
    if (rsp_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL push_same_cycle: rdy=%b v0=%b, want 0 0", rsp_ready, rsp0_valid);
    end
    tick();
    drive(0, 0, 0, 1, 1, 1);
    checks++;
    if (rsp_ready !== 1'b1 || rsp0_valid !== 1'b1 || rsp0_last !== 1'b0) begin
      errors++;
      $display("FAIL push_next_cycle: rdy=%b v0=%b last=%b, want 1 1 0", rsp_ready, rsp0_valid, rsp0_last);
    end
    drain("rst");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] exp_f, obs_f;
      int size = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), size,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      exp_f = {m_valid(0), m_valid(1), m_ready(), mq.size() == DEPTH, mq.size() == 0, merr};
      obs_f = {rsp0_valid, rsp1_valid, rsp_ready, arb_busy, idle, err_ovf};
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL rand_flags c%0d: v0,v1,rdy,busy,idle,err=%b, want %b", c, obs_f, exp_f);
      end
      checks++;
      if (outs0_cnt !== CW'(m_outs(0)) || outs1_cnt !== CW'(m_outs(1))) begin
        errors++;
        $display("FAIL rand_outs c%0d: outs0=%0d outs1=%0d, want %0d %0d",
                 c, outs0_cnt, outs1_cnt, m_outs(0), m_outs(1));
      end
      if (m_valid(0) || m_valid(1)) begin
        checks++;
        if ((m_valid(1) ? rsp1_last : rsp0_last) !== m_last() ||
            (m_valid(1) ? rsp1_pd : rsp0_pd) !== rsp_pd) begin
          errors++;
          $display("FAIL rand_beat c%0d: last0=%b last1=%b want_last=%b pd_ok=%b",
                   c, rsp0_last, rsp1_last, m_last(), (m_valid(1) ? rsp1_pd : rsp0_pd) === rsp_pd);
        end
      end
      tick();
    end
    drain("rand");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_mixed_route();
    test_backpressure();
    test_push_pop_same();
    test_full_overflow();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
